trap_ctrl: RTL and testbench

//  Trap/interrupt responder for the single-cycle RISC-V core. It takes the ecall and uret

---
 rtl/trap_if.sv | 32 +++
 rtl/trap_ctrl.sv | 117 +++++++++++
 tb/tb_trap_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_if.sv
// Trap controller bus: decoder strobes, interrupt lines and PCs in, redirect and trap state out.
interface trap_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NIRQ = 3
);
    logic            retire;
    logic            ecall;
    logic            uret;
    logic [NIRQ-1:0] irq;
    logic [XLEN-1:0] pc_cur;
    logic [XLEN-1:0] pc_next;
    logic            redirect;
    logic [XLEN-1:0] pc_target;
    logic            in_trap;
    logic            ie;
    logic [NIRQ-1:0] pending;
    logic [3:0]      ucause;
    logic [XLEN-1:0] uepc;
    logic            err;

    // Core side
    modport master (
        output retire, ecall, uret, irq, pc_cur, pc_next,
        input  redirect, pc_target, in_trap, ie, pending, ucause, uepc, err
    );

    // Trap controller side
    modport slave (
        input  retire, ecall, uret, irq, pc_cur, pc_next,
        output redirect, pc_target, in_trap, ie, pending, ucause, uepc, err
    );
endinterface

// File: rtl/trap_ctrl.sv
// Non-nested trap/interrupt responder: ecall/uret handling, synchronized and edge-latched
// interrupt requests, and the PC redirect for the next-PC mux.
module trap_ctrl #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NIRQ      = 3,
    parameter logic [XLEN-1:0] VEC_BASE  = 'h100,
    parameter int unsigned     VEC_SHIFT = 4,
    parameter bit              IE_RST    = 1'b1
) (
    input logic   clk,
    input logic   rst,
    trap_if.slave bus
);
    typedef enum logic {StIdle, StTrap} state_e;

    state_e          state_q, state_d;
    logic [NIRQ-1:0] sync1_q, sync2_q, prev_q;
    logic [NIRQ-1:0] pending_q, pending_d, pend_clr, irq_edge;
    logic            ie_q, ie_d;
    logic            err_q, err_d;
    logic [3:0]      ucause_q, ucause_d, hi_idx, irq_cause;
    logic [XLEN-1:0] uepc_q, uepc_d;
    logic            irq_take;

    assign irq_edge  = sync2_q & ~prev_q;
    assign irq_cause = hi_idx + 4'd1;
    assign irq_take  = bus.retire & ie_q & (|pending_q) & ~bus.ecall & ~bus.uret &
                       (state_q == StIdle);

    // Highest-index pending source; later iterations overwrite lower ones
    always_comb begin
        hi_idx = 4'd0;
        for (int i = 0; i < int'(NIRQ); i++) begin
            if (pending_q[i]) hi_idx = 4'(i);
        end
    end

    // Next-state, trap bookkeeping and redirect decode
    always_comb begin
        state_d       = state_q;
        ie_d          = ie_q;
        err_d         = err_q;
        ucause_d      = ucause_q;
        uepc_d        = uepc_q;
        pend_clr      = '0;
        bus.redirect  = 1'b0;
        bus.pc_target = bus.pc_next;
        unique case (state_q)
            StIdle: begin
                if (bus.retire && bus.ecall) begin
                    // ecall wins over a simultaneous interrupt, which stays pending
                    state_d       = StTrap;
                    uepc_d        = bus.pc_cur + XLEN'(4);
                    ucause_d      = 4'd0;
                    ie_d          = 1'b0;
                    bus.redirect  = 1'b1;
                    bus.pc_target = VEC_BASE;
                end else if (irq_take) begin
                    state_d       = StTrap;
                    uepc_d        = bus.pc_next;
                    ucause_d      = irq_cause;
                    ie_d          = 1'b0;
                    pend_clr      = NIRQ'(1) << hi_idx;
                    bus.redirect  = 1'b1;
                    bus.pc_target = VEC_BASE + (XLEN'(irq_cause) << VEC_SHIFT);
                end else if (bus.retire && bus.uret) begin
                    err_d = 1'b1;
                end
            end
            StTrap: begin
                if (bus.retire && bus.uret) begin
                    state_d       = StIdle;
                    ie_d          = 1'b1;
                    bus.redirect  = 1'b1;
                    bus.pc_target = uepc_q;
                end else if (bus.retire && bus.ecall) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A fresh edge re-arms a source even in the cycle it is taken
        pending_d = (pending_q & ~pend_clr) | irq_edge;
    end

    // State, trap registers, synchronizers and pending latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ie_q      <= IE_RST;
            err_q     <= 1'b0;
            ucause_q  <= 4'd0;
            uepc_q    <= '0;
            pending_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            err_q     <= err_d;
            ucause_q  <= ucause_d;
            uepc_q    <= uepc_d;
            pending_q <= pending_d;
            sync1_q   <= bus.irq;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
        end
    end

    assign bus.in_trap = (state_q == StTrap);
    assign bus.ie      = ie_q;
    assign bus.pending = pending_q;
    assign bus.ucause  = ucause_q;
    assign bus.uepc    = uepc_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios, a behavioural model checked every cycle,
// and literal expectations pinning the key scenario results.
module tb_trap_ctrl;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NIRQ = 3;
    localparam logic [31:0] VEC  = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_if #(.XLEN(XLEN), .NIRQ(NIRQ)) bus ();

    trap_ctrl #(.XLEN(XLEN), .NIRQ(NIRQ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    // Model state
    bit              m_trap;
    bit              m_ie;
    bit              m_err;
    logic [NIRQ-1:0] m_pend;
    logic [3:0]      m_cause;
    logic [31:0]     m_uepc;
    logic [NIRQ-1:0] hist [0:1023];
    int              ncyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hi_pend(input logic [NIRQ-1:0] p);
        for (int i = NIRQ - 1; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    // Model update: a rising irq level sampled at edge n becomes pending at edge n+2
    always @(posedge clk) begin
        int hi;
        logic [NIRQ-1:0] set;
        logic [NIRQ-1:0] clr;
        if (rst) begin
            m_trap = 0; m_ie = 1; m_err = 0; m_pend = '0; m_cause = 0; m_uepc = 0;
            hist[ncyc] = '0;
            if (ncyc >= 1) hist[ncyc-1] = '0;
            if (ncyc >= 2) hist[ncyc-2] = '0;
        end else begin
            set = (ncyc >= 3) ? (hist[ncyc-2] & ~hist[ncyc-3]) : '0;
            clr = '0;
            hi  = hi_pend(m_pend);
            if (!m_trap) begin
                if (bus.retire && bus.ecall) begin
                    m_trap = 1; m_ie = 0; m_cause = 0; m_uepc = bus.pc_cur + 32'd4;
                end else if (bus.retire && m_ie && hi >= 0 && !bus.uret) begin
                    m_trap = 1; m_ie = 0; m_cause = 4'(hi + 1); m_uepc = bus.pc_next;
                    clr[hi] = 1'b1;
                end else if (bus.retire && bus.uret) begin
                    m_err = 1;
                end
            end else begin
                if (bus.retire && bus.uret) begin
                    m_trap = 0; m_ie = 1;
                end else if (bus.retire && bus.ecall) begin
                    m_err = 1;
                end
            end
            m_pend = (m_pend & ~clr) | set;
            hist[ncyc] = bus.irq;
        end
        ncyc++;
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        bit          e_red;
        logic [31:0] e_tgt;
        int          hi;
        if (started) begin
            e_red = 0;
            e_tgt = bus.pc_next;
            hi    = hi_pend(m_pend);
            if (!m_trap && bus.retire && bus.ecall) begin
                e_red = 1; e_tgt = VEC;
            end else if (!m_trap && bus.retire && m_ie && hi >= 0 && !bus.uret) begin
                e_red = 1; e_tgt = VEC + 32'((hi + 1) * 16);
            end else if (m_trap && bus.retire && bus.uret) begin
                e_red = 1; e_tgt = m_uepc;
            end
            if (!rst) begin
                chk("redirect", 32'(bus.redirect), 32'(e_red));
                chk("pc_target", bus.pc_target, e_tgt);
            end
            chk("in_trap", 32'(bus.in_trap), 32'(m_trap));
            chk("ie", 32'(bus.ie), 32'(m_ie));
            chk("pending", 32'(bus.pending), 32'(m_pend));
            chk("ucause", 32'(bus.ucause), 32'(m_cause));
            chk("uepc", bus.uepc, m_uepc);
            chk("err", 32'(bus.err), 32'(m_err));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic rt, input logic ec, input logic ur);
        bus.retire = rt; bus.ecall = ec; bus.uret = ur;
        #2;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) hist[i] = '0;
        bus.retire = 0; bus.ecall = 0; bus.uret = 0; bus.irq = '0;
        bus.pc_cur = 32'h0; bus.pc_next = 32'h4;
        rst = 1;
        tick(2);
        rst = 0;
        started = 1;
        #2;
        chk("rst_ie", 32'(bus.ie), 32'd1);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_in_trap", 32'(bus.in_trap), 32'd0);

        // 1: ecall entry
        bus.pc_cur = 32'h40; bus.pc_next = 32'h44;
        drive(1, 1, 0);
        chk("s1_redirect", 32'(bus.redirect), 32'd1);
        chk("s1_target", bus.pc_target, 32'h100);
        tick();
        drive(0, 0, 0);
        chk("s1_uepc", bus.uepc, 32'h44);
        chk("s1_ucause", 32'(bus.ucause), 32'd0);
        chk("s1_in_trap", 32'(bus.in_trap), 32'd1);
        chk("s1_ie", 32'(bus.ie), 32'd0);

        // 2: uret return
        drive(1, 0, 1);
        chk("s2_target", bus.pc_target, 32'h44);
        tick();
        drive(0, 0, 0);
        chk("s2_in_trap", 32'(bus.in_trap), 32'd0);
        chk("s2_ie", 32'(bus.ie), 32'd1);

        // 3: two simultaneous irq edges, highest first
        bus.irq = 3'b101;
        tick(3);
        #2;
        chk("s3_pending", 32'(bus.pending), 32'b101);
        bus.pc_cur = 32'h7c; bus.pc_next = 32'h80;
        drive(1, 0, 0);
        chk("s3_target", bus.pc_target, 32'h130);
        tick();
        drive(0, 0, 0);
        chk("s3_ucause", 32'(bus.ucause), 32'd3);
        chk("s3_uepc", bus.uepc, 32'h80);
        chk("s3_pend_left", 32'(bus.pending), 32'b001);
        drive(1, 0, 1);
        tick();
        bus.pc_next = 32'h90;
        drive(1, 0, 0);
        chk("s3_irq0_target", bus.pc_target, 32'h110);
        tick();
        drive(1, 0, 1);
        tick();
        bus.irq = 3'b000;
        drive(0, 0, 0);
        tick(4);

        // 4: ecall beats pending irq1
        bus.irq = 3'b010;
        tick(3);
        bus.pc_cur = 32'h200; bus.pc_next = 32'h204;
        drive(1, 1, 0);
        chk("s4_target", bus.pc_target, 32'h100);
        tick();
        drive(0, 0, 0);
        chk("s4_pending", 32'(bus.pending), 32'b010);
        drive(1, 0, 1);
        tick();
        drive(1, 0, 0);
        chk("s4_irq1_target", bus.pc_target, 32'h120);
        tick();
        drive(1, 0, 1);
        tick();
        bus.irq = 3'b000;
        drive(0, 0, 0);
        tick(4);

        // 5: irq2 arrives during a handler, taken only after uret
        drive(1, 1, 0);
        tick();
        bus.irq = 3'b100;
        drive(0, 0, 0);
        tick(3);
        #2;
        chk("s5_pending", 32'(bus.pending), 32'b100);
        drive(1, 0, 0);
        chk("s5_no_redirect", 32'(bus.redirect), 32'd0);
        tick();
        drive(1, 1, 0);
        chk("s5_nested_ecall", 32'(bus.redirect), 32'd0);
        tick();
        drive(1, 0, 1);
        tick();
        drive(1, 0, 0);
        chk("s5_irq2_target", bus.pc_target, 32'h130);
        tick();
        drive(1, 0, 1);
        tick();
        bus.irq = 3'b000;
        drive(0, 0, 0);
        tick(4);

        // 6: reset mid-trap, then illegal uret in IDLE
        bus.irq = 3'b011;
        tick(3);
        drive(1, 1, 0);
        tick();
        drive(0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        #2;
        chk("s6_in_trap", 32'(bus.in_trap), 32'd0);
        chk("s6_ie", 32'(bus.ie), 32'd1);
        chk("s6_pending", 32'(bus.pending), 32'd0);
        chk("s6_uepc", bus.uepc, 32'd0);
        chk("s6_err", 32'(bus.err), 32'd0);
        drive(1, 0, 1);
        chk("s6_uret_noredir", 32'(bus.redirect), 32'd0);
        tick();
        drive(0, 0, 0);
        chk("s6_err_set", 32'(bus.err), 32'd1);

        // pc_cur + 4 wraps
        bus.pc_cur = 32'hFFFF_FFFC; bus.pc_next = 32'h0;
        drive(1, 1, 0);
        tick();
        drive(0, 0, 0);
        chk("wrap_uepc", bus.uepc, 32'h0);
        tick(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
